// File: rtl/pipeline_backbone.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_backbone
// Description : Parametrised inter-stage register chain with centralised
//               stall/flush control and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_backbone #(
    parameter int NUM_STAGES  = 4,
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic [NUM_STAGES-1:0]         flush_req,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic [NUM_STAGES*WIDTH-1:0]   stage_data,
    output logic [NUM_STAGES-1:0]         hold,
    output logic                          out_fire,
    output logic [COUNT_WIDTH-1:0]        retired_count,
    output logic [COUNT_WIDTH-1:0]        stall_count,
    output logic [COUNT_WIDTH-1:0]        flush_count
);

    localparam logic [COUNT_WIDTH-1:0] c_cnt_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] c_cnt_max = {COUNT_WIDTH{1'b1}};

    logic [NUM_STAGES-1:0]             r_valid;
    logic [NUM_STAGES-1:0][WIDTH-1:0]  r_data;

    logic [NUM_STAGES-1:0]             w_flush_eff;
    logic [NUM_STAGES-1:0]             w_kill;
    logic [NUM_STAGES-1:0]             w_stall_eff;
    logic [NUM_STAGES-1:0]             w_hold_raw;
    logic [NUM_STAGES-1:0]             w_hold;
    logic [NUM_STAGES-1:0]             w_bubble;
    logic [NUM_STAGES-1:0]             w_src_valid;
    logic [NUM_STAGES-1:0][WIDTH-1:0]  w_src_data;
    logic [NUM_STAGES-1:0]             w_nxt_valid;
    logic [NUM_STAGES-1:0][WIDTH-1:0]  w_nxt_data;
    logic                              w_flush_active;
    logic                              w_stall_active;
    logic                              w_in_ready;
    logic                              w_out_fire;

    logic [COUNT_WIDTH-1:0]            r_retired;
    logic [COUNT_WIDTH-1:0]            r_stalls;
    logic [COUNT_WIDTH-1:0]            r_flushes;

    // Kill mask: a register dies when any older valid register redirects.
    // Hold mask: everything at or below the oldest surviving stall requester.
    always_comb begin
        w_flush_eff = flush_req & r_valid;
        w_kill      = '0;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_kill[i] = w_kill[i+1] | w_flush_eff[i+1];
        end

        w_stall_eff = stall_req & r_valid & ~w_kill;
        w_hold_raw  = '0;
        w_hold_raw[NUM_STAGES-1] = w_stall_eff[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_hold_raw[i] = w_hold_raw[i+1] | w_stall_eff[i];
        end

        w_hold   = w_hold_raw & ~w_kill;
        w_bubble = '0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_bubble[i] = w_hold_raw[i-1] & ~w_hold_raw[i];
        end
    end

    assign w_flush_active = |w_flush_eff;
    assign w_stall_active = |w_stall_eff;
    assign w_in_ready     = ~w_stall_active & ~w_flush_active;
    assign w_out_fire     = r_valid[NUM_STAGES-1] & ~w_hold[NUM_STAGES-1];

    // A register fed by a killed neighbour receives an empty slot.
    always_comb begin
        w_src_valid    = '0;
        w_src_data     = '0;
        w_src_valid[0] = in_valid & w_in_ready;
        w_src_data[0]  = in_data;
        for (int i = 1; i < NUM_STAGES; i++) begin
            w_src_valid[i] = r_valid[i-1] & ~w_kill[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    always_comb begin
        w_nxt_valid = r_valid;
        w_nxt_data  = r_data;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (w_kill[i]) begin
                w_nxt_valid[i] = 1'b0;
            end else if (!w_hold[i]) begin
                if (w_bubble[i]) begin
                    w_nxt_valid[i] = 1'b0;
                end else begin
                    w_nxt_valid[i] = w_src_valid[i];
                    w_nxt_data[i]  = w_src_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_data  <= w_nxt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_stalls  <= '0;
            r_flushes <= '0;
        end else begin
            if (w_out_fire && (r_retired != c_cnt_max)) begin
                r_retired <= r_retired + c_cnt_one;
            end
            if (w_stall_active && (r_stalls != c_cnt_max)) begin
                r_stalls <= r_stalls + c_cnt_one;
            end
            if (w_flush_active && (r_flushes != c_cnt_max)) begin
                r_flushes <= r_flushes + c_cnt_one;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign stage_valid   = r_valid;
    assign stage_data    = r_data;
    assign hold          = w_hold;
    assign out_fire      = w_out_fire;
    assign retired_count = r_retired;
    assign stall_count   = r_stalls;
    assign flush_count   = r_flushes;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_backbone.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_backbone
// Description : Randomised and directed bench for pipeline_backbone with an
//               array-based reference model of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_backbone;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic [N-1:0]     stall_req;
    logic [N-1:0]     flush_req;

    logic             in_ready;
    logic [N-1:0]     stage_valid;
    logic [N*W-1:0]   stage_data;
    logic [N-1:0]     hold;
    logic             out_fire;
    logic [CW-1:0]    retired_count, stall_count, flush_count;

    logic             in_ready_s;
    logic [N-1:0]     stage_valid_s;
    logic [N*W-1:0]   stage_data_s;
    logic [N-1:0]     hold_s;
    logic             out_fire_s;
    logic [CWS-1:0]   retired_count_s, stall_count_s, flush_count_s;

    pipeline_backbone #(.NUM_STAGES(N), .WIDTH(W), .COUNT_WIDTH(CW)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .stage_valid(stage_valid), .stage_data(stage_data), .hold(hold),
        .out_fire(out_fire), .retired_count(retired_count),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_backbone #(.NUM_STAGES(N), .WIDTH(W), .COUNT_WIDTH(CWS)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .stall_req(stall_req), .flush_req(flush_req),
        .stage_valid(stage_valid_s), .stage_data(stage_data_s), .hold(hold_s),
        .out_fire(out_fire_s), .retired_count(retired_count_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint satv(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic logic [W-1:0] dslice(input logic [N*W-1:0] bus, input int i);
        return bus[i*W +: W];
    endfunction

    // Reference model: pipeline contents as plain arrays plus event totals.
    bit [N-1:0]   mv;
    logic [W-1:0] md [N];
    bit [N-1:0]   nv;
    logic [W-1:0] nd [N];
    longint       cr, cs, cf;
    bit           model_ok = 1'b0;
    int           mf, ms;
    bit [N-1:0]   eh;
    bit           er, ef;

    always @(negedge clk) begin
        mf = -1;
        for (int i = 0; i < N; i++) if (flush_req[i] && mv[i]) mf = i;
        ms = -1;
        for (int i = 0; i < N; i++) if (stall_req[i] && mv[i] && i >= mf) ms = i;
        for (int i = 0; i < N; i++) eh[i] = (ms >= 0) && (i <= ms) && (i >= mf);
        er = (ms < 0) && (mf < 0);
        ef = mv[N-1] && !eh[N-1];

        if (model_ok) begin
            chk("stage_valid", stage_valid, mv);
            for (int i = 0; i < N; i++) if (mv[i]) chk("stage_data", dslice(stage_data, i), md[i]);
            chk("hold", hold, eh);
            chk("in_ready", in_ready, er);
            chk("out_fire", out_fire, ef);
            chk("retired_count", retired_count, satv(cr, CW));
            chk("stall_count", stall_count, satv(cs, CW));
            chk("flush_count", flush_count, satv(cf, CW));
            chk("sat_retired", retired_count_s, satv(cr, CWS));
            chk("sat_stall", stall_count_s, satv(cs, CWS));
            chk("sat_flush", flush_count_s, satv(cf, CWS));
        end

        if (reset) begin
            mv = '0;
            for (int i = 0; i < N; i++) md[i] = '0;
            cr = 0; cs = 0; cf = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int i = 0; i < N; i++) begin
                nv[i] = mv[i];
                nd[i] = md[i];
                if (i < mf) begin
                    nv[i] = 1'b0;
                end else if (eh[i]) begin
                    nv[i] = mv[i];
                end else if (ms >= 0 && i == ms + 1) begin
                    nv[i] = 1'b0;
                end else if (i > 0) begin
                    nv[i] = mv[i-1] && !((i - 1) < mf);
                    nd[i] = md[i-1];
                end else begin
                    nv[i] = in_valid && er;
                    nd[i] = in_data;
                end
            end
            mv = nv;
            for (int i = 0; i < N; i++) md[i] = nd[i];
            cr += ef ? 1 : 0;
            cs += (ms >= 0) ? 1 : 0;
            cf += (mf >= 0) ? 1 : 0;
        end
    end

    task automatic step(input bit r, input bit v, input logic [W-1:0] d,
                        input logic [N-1:0] st, input logic [N-1:0] fl);
        @(posedge clk);
        #1;
        reset     = r;
        in_valid  = v;
        in_data   = d;
        stall_req = st;
        flush_req = fl;
    endtask

    // Leaves register k holding 16'hB000+k, all valid, counters cleared.
    task automatic rst_fill();
        step(1'b1, 1'b0, '0, '0, '0);
        for (int k = 3; k >= 0; k--) step(1'b0, 1'b1, W'(16'hB000 + k), '0, '0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0; flush_req = '0;
        step(1'b1, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("rst_valid", stage_valid, 4'b0000);
        chk("rst_data", stage_data, 64'h0);
        chk("rst_retired", retired_count, 0);

        // Straight stream, fixed latency
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, W'(16'hA000 + k), '0, '0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, '0, '0, '0);
            @(negedge clk);
            chk("s1_fire", out_fire, 1);
            chk("s1_data3", dslice(stage_data, 3), 16'hA000 + k);
        end
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s1_retired", retired_count, 4);
        chk("s1_sat_retired", retired_count_s, 3);

        // Stall at register 2 for two cycles
        rst_fill();
        step(1'b0, 1'b1, 16'hC000, 4'b0100, '0);
        @(negedge clk);
        chk("s2_hold", hold, 4'b0111);
        chk("s2_ready", in_ready, 0);
        chk("s2_fire", out_fire, 1);
        step(1'b0, 1'b1, 16'hC000, 4'b0100, '0);
        @(negedge clk);
        chk("s2_valid", stage_valid, 4'b0111);
        for (int k = 0; k < 3; k++) chk("s2_data", dslice(stage_data, k), 16'hB000 + k);
        chk("s2_ready2", in_ready, 0);
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s2_stall_count", stall_count, 2);
        chk("s2_resume", in_ready, 1);

        // Flush at register 2
        rst_fill();
        step(1'b0, 1'b1, 16'hC001, '0, 4'b0100);
        @(negedge clk);
        chk("s3_ready", in_ready, 0);
        chk("s3_fire", out_fire, 1);
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s3_valid", stage_valid, 4'b1000);
        chk("s3_data3", dslice(stage_data, 3), 16'hB002);
        chk("s3_flush_count", flush_count, 1);

        // Flush plus stall from a killed requester
        rst_fill();
        step(1'b0, 1'b0, '0, 4'b0010, 4'b0100);
        @(negedge clk);
        chk("s4_hold", hold, 4'b0000);
        chk("s4_ready", in_ready, 0);
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s4_valid", stage_valid, 4'b1000);
        chk("s4_data3", dslice(stage_data, 3), 16'hB002);
        chk("s4_stall_count", stall_count, 0);
        chk("s4_flush_count", flush_count, 1);

        // Flush plus stall from a surviving requester
        rst_fill();
        step(1'b0, 1'b1, 16'hC002, 4'b1000, 4'b0010);
        @(negedge clk);
        chk("s5_hold", hold, 4'b1110);
        chk("s5_ready", in_ready, 0);
        chk("s5_fire", out_fire, 0);
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s5_valid", stage_valid, 4'b1110);
        for (int k = 1; k < 4; k++) chk("s5_data", dslice(stage_data, k), 16'hB000 + k);
        chk("s5_stall_count", stall_count, 1);
        chk("s5_flush_count", flush_count, 1);

        // Stall request on an empty register is ignored
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 16'hD000, 4'b0010, '0);
        @(negedge clk);
        chk("s6_hold", hold, 4'b0000);
        chk("s6_ready", in_ready, 1);

        // Random traffic; the model process checks every cycle
        repeat (3000) begin
            step(($urandom_range(0, 299) == 0), $urandom_range(0, 3) != 0, W'($urandom),
                 N'(($urandom_range(0, 7) == 0) ? $urandom : 0),
                 N'(($urandom_range(0, 11) == 0) ? $urandom : 0));
        end

        // Reset mid-stream
        repeat (10) step(1'b0, 1'b1, W'($urandom), '0, '0);
        step(1'b1, 1'b1, 16'hE000, 4'b0001, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("s6_rst_valid", stage_valid, 4'b0000);
        chk("s6_rst_retired", retired_count, 0);
        chk("s6_rst_stall", stall_count, 0);
        chk("s6_rst_flush", flush_count, 0);

        repeat (3) step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
